// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: NOP encoding, default reset PC,
// the buffered {instr, pc} entry type and a word-align helper.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          BUF_DEPTH        = 2;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// 2-entry synchronous FIFO of {instr, pc} absorbing fetch responses.
// Ports: push/pop/flush controls, count (0-2), head_instr/head_pc.
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        push,
    input  logic [31:0] push_instr,
    input  logic [31:0] push_pc,
    input  logic        pop,
    output logic [1:0]  count,
    output logic [31:0] head_instr,
    output logic [31:0] head_pc
);

    fetch_entry_t mem_q [BUF_DEPTH];
    fetch_entry_t mem_d [BUF_DEPTH];
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    always_comb begin
        do_push  = push && (count_q != 2'd2);
        do_pop   = pop && (count_q != 2'd0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = '{instr: push_instr, pc: push_pc};
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign count      = count_q;
    assign head_instr = mem_q[rd_ptr_q].instr;
    assign head_pc    = mem_q[rd_ptr_q].pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns pc_f, issues imem requests under a 2-credit
// limit, buffers responses during stalls and drives the IF/ID register.
// Ports: imem_req/addr/ready/rdata, stall_d, redirect_e/pc_e,
// instr_d/imm_d/pc_d/pc_plus4_d/valid_d.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall_d,
    input  logic        redirect_e,
    input  logic [31:0] redirect_pc_e,
    output logic [31:0] instr_d,
    output logic [24:0] imm_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d
);

    logic [31:0] pcf_q, pcf_d;
    logic [31:0] resp_pc_q, resp_pc_d;
    logic        inflight_q, inflight_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;

    logic [1:0]  buf_count;
    logic [31:0] head_instr, head_pc;
    logic [2:0]  credit;
    logic        accept, resp_live, bypass;
    logic        push, pop, buf_flush;

    fetch_buffer u_buf (
        .clk        (clk),
        .reset      (reset),
        .flush      (buf_flush),
        .push       (push),
        .push_instr (imem_rdata),
        .push_pc    (resp_pc_q),
        .pop        (pop),
        .count      (buf_count),
        .head_instr (head_instr),
        .head_pc    (head_pc)
    );

    // Credits cover buffered entries plus the response still in
    // flight, so a buffer slot always exists for every response.
    always_comb begin
        credit    = {1'b0, buf_count} + {2'b00, inflight_q};
        imem_req  = !reset && !redirect_e && (credit < 3'd2);
        accept    = imem_req && imem_ready;
        resp_live = inflight_q && !redirect_e && !reset;
        bypass    = resp_live && (buf_count == 2'd0) && !stall_d;
        push      = resp_live && !bypass;
        pop       = !reset && !redirect_e && !stall_d
                    && (buf_count != 2'd0);
        buf_flush = reset || redirect_e;
    end

    always_comb begin
        pcf_d      = pcf_q;
        inflight_d = accept;
        resp_pc_d  = resp_pc_q;
        if (redirect_e) begin
            pcf_d = word_align(redirect_pc_e);
        end else if (accept) begin
            pcf_d = pcf_q + 32'd4;
        end
        if (accept) begin
            resp_pc_d = pcf_q;
        end
    end

    // Buffer head has priority over the bypass so order is kept.
    always_comb begin
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        if (redirect_e) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
        end else if (!stall_d) begin
            if (pop) begin
                ifid_instr_d = head_instr;
                ifid_pc_d    = head_pc;
                ifid_pc4_d   = head_pc + 32'd4;
                ifid_valid_d = 1'b1;
            end else if (bypass) begin
                ifid_instr_d = imem_rdata;
                ifid_pc_d    = resp_pc_q;
                ifid_pc4_d   = resp_pc_q + 32'd4;
                ifid_valid_d = 1'b1;
            end else begin
                ifid_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcf_q        <= word_align(RESET_PC);
            resp_pc_q    <= 32'd0;
            inflight_q   <= 1'b0;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= 32'd0;
            ifid_pc4_q   <= 32'd0;
            ifid_valid_q <= 1'b0;
        end else begin
            pcf_q        <= pcf_d;
            resp_pc_q    <= resp_pc_d;
            inflight_q   <= inflight_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign imem_addr  = pcf_q;
    assign instr_d    = ifid_instr_q;
    assign imm_d      = ifid_instr_q[31:7];
    assign pc_d       = ifid_pc_q;
    assign pc_plus4_d = ifid_pc4_q;
    assign valid_d    = ifid_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage: one vector per clock cycle,
// inputs driven after the rising edge, outputs checked on the falling.
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam logic [31:0] XORK = 32'hA5A5_0000;
    localparam int K_REQ = 1;
    localparam int K_ADR = 2;
    localparam int K_VLD = 4;
    localparam int K_PC  = 8;
    localparam int K_NOP = 16;
    localparam int K_Z   = 32;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        stl;
        logic        rdr;
        logic [31:0] rpc;
        int          ck;
        logic        er;
        logic [31:0] ea;
        logic        ev;
        logic [31:0] ep;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall_d;
    logic        redirect_e;
    logic [31:0] redirect_pc_e;
    logic [31:0] instr_d;
    logic [24:0] imm_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;

    int   n_total = 0;
    int   n_bad   = 0;
    vec_t tv[$];

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .stall_d       (stall_d),
        .redirect_e    (redirect_e),
        .redirect_pc_e (redirect_pc_e),
        .instr_d       (instr_d),
        .imm_d         (imm_d),
        .pc_d          (pc_d),
        .pc_plus4_d    (pc_plus4_d),
        .valid_d       (valid_d)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory returns addr ^ XORK one cycle after an accepted request.
    always @(posedge clk) begin
        if (imem_req && imem_ready)
            imem_rdata <= imem_addr ^ XORK;
        else
            imem_rdata <= 32'hBAD0_0BAD;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic add(input logic rst, input logic rdy,
                       input logic stl, input logic rdr,
                       input logic [31:0] rpc, input int ck,
                       input logic er, input logic [31:0] ea,
                       input logic ev, input logic [31:0] ep);
        vec_t t;
        t.rst = rst; t.rdy = rdy; t.stl = stl; t.rdr = rdr;
        t.rpc = rpc; t.ck = ck;
        t.er = er; t.ea = ea; t.ev = ev; t.ep = ep;
        tv.push_back(t);
    endtask

    initial begin
        logic [31:0] ei;
        reset = 1'b1; imem_ready = 1'b1; stall_d = 1'b0;
        redirect_e = 1'b0; redirect_pc_e = 32'd0;

        // reset
        add(1,1,0,0,0, 0, 0,0,0,0);
        add(1,1,0,0,0, K_REQ|K_VLD|K_NOP|K_Z, 0,0,0,0);
        // streaming from RESET_PC
        add(0,1,0,0,0, K_REQ|K_ADR|K_VLD, 1,32'h0,0,0);
        add(0,1,0,0,0, K_ADR, 1,32'h4,0,0);
        add(0,1,0,0,0, K_ADR|K_VLD|K_PC, 1,32'h8,1,32'h0);
        // 5-cycle stall
        add(0,1,1,0,0, K_REQ|K_ADR|K_VLD|K_PC, 1,32'hC,1,32'h4);
        add(0,1,1,0,0, K_REQ|K_VLD|K_PC, 0,0,1,32'h4);
        add(0,1,1,0,0, K_REQ, 0,0,0,0);
        add(0,1,1,0,0, K_VLD|K_PC, 0,0,1,32'h4);
        add(0,1,1,0,0, K_REQ|K_VLD|K_PC, 0,0,1,32'h4);
        add(0,1,0,0,0, K_REQ|K_PC, 0,0,1,32'h4);
        add(0,1,0,0,0, K_REQ|K_ADR|K_VLD|K_PC, 1,32'h10,1,32'h8);
        add(0,1,0,0,0, K_ADR|K_VLD|K_PC, 1,32'h14,1,32'hC);
        add(0,1,0,0,0, K_ADR|K_VLD|K_PC, 1,32'h18,1,32'h10);
        // redirect with response in flight
        add(0,1,0,1,32'h103, K_REQ|K_VLD|K_PC, 0,0,1,32'h14);
        add(0,1,0,0,0, K_REQ|K_ADR|K_VLD|K_NOP, 1,32'h100,0,0);
        add(0,1,0,0,0, K_ADR|K_VLD, 1,32'h104,0,0);
        add(0,1,0,0,0, K_ADR|K_VLD|K_PC, 1,32'h108,1,32'h100);
        // ready toggling
        add(0,0,0,0,0, K_REQ|K_ADR|K_PC, 1,32'h10C,1,32'h104);
        add(0,1,0,0,0, K_REQ|K_ADR|K_PC, 1,32'h10C,1,32'h108);
        add(0,0,0,0,0, K_ADR|K_VLD, 1,32'h110,0,0);
        add(0,1,0,0,0, K_ADR|K_VLD|K_PC, 1,32'h110,1,32'h10C);
        add(0,1,0,0,0, K_ADR|K_VLD, 1,32'h114,0,0);
        add(0,1,0,0,0, K_ADR|K_PC, 1,32'h118,1,32'h110);
        // redirect to top of address space
        add(0,1,0,1,32'hFFFF_FFFC, K_REQ|K_PC, 0,0,1,32'h114);
        add(0,1,0,0,0, K_REQ|K_ADR|K_VLD|K_NOP, 1,32'hFFFF_FFFC,0,0);
        add(0,1,0,0,0, K_ADR|K_VLD, 1,32'h0,0,0);
        add(0,1,0,0,0, K_ADR|K_VLD|K_PC, 1,32'h4,1,32'hFFFF_FFFC);
        // fill buffer, then reset
        add(0,1,1,0,0, K_REQ|K_ADR|K_VLD|K_PC, 1,32'h8,1,32'h0);
        add(0,1,1,0,0, K_REQ|K_PC, 0,0,1,32'h0);
        add(1,1,1,0,0, K_REQ|K_VLD|K_PC, 0,0,1,32'h0);
        add(1,1,1,0,0, K_REQ|K_VLD|K_NOP|K_Z, 0,0,0,0);
        add(0,1,0,0,0, K_REQ|K_ADR|K_VLD, 1,32'h0,0,0);
        add(0,1,0,0,0, K_ADR|K_VLD, 1,32'h4,0,0);
        add(0,1,0,0,0, K_ADR|K_VLD|K_PC, 1,32'h8,1,32'h0);

        @(posedge clk);
        #1;
        foreach (tv[i]) begin
            reset         = tv[i].rst;
            imem_ready    = tv[i].rdy;
            stall_d       = tv[i].stl;
            redirect_e    = tv[i].rdr;
            redirect_pc_e = tv[i].rpc;
            @(negedge clk);
            if ((tv[i].ck & K_REQ) != 0)
                check($sformatf("req@%0d", i),
                      {31'd0, imem_req}, {31'd0, tv[i].er});
            if ((tv[i].ck & K_ADR) != 0)
                check($sformatf("addr@%0d", i), imem_addr, tv[i].ea);
            if ((tv[i].ck & K_VLD) != 0)
                check($sformatf("valid@%0d", i),
                      {31'd0, valid_d}, {31'd0, tv[i].ev});
            if ((tv[i].ck & K_PC) != 0) begin
                ei = tv[i].ep ^ XORK;
                check($sformatf("pc@%0d", i), pc_d, tv[i].ep);
                check($sformatf("pc4@%0d", i), pc_plus4_d,
                      tv[i].ep + 32'd4);
                check($sformatf("instr@%0d", i), instr_d, ei);
                check($sformatf("imm@%0d", i),
                      {7'd0, imm_d}, {7'd0, ei[31:7]});
            end
            if ((tv[i].ck & K_NOP) != 0)
                check($sformatf("nop@%0d", i), instr_d, 32'h0000_0013);
            if ((tv[i].ck & K_Z) != 0) begin
                check($sformatf("pcz@%0d", i), pc_d, 32'd0);
                check($sformatf("pc4z@%0d", i), pc_plus4_d, 32'd0);
            end
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
